// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures the half-period of a divided square wave (slow_in) in cycles of
//   the fast clock, and reports the equivalent scaler setting (half-period - 1)
//   once two consecutive half-periods agree.
//
// Parameters
//   SCALER_WIDTH  scaler_out and the interval counter are SCALER_WIDTH+1 bits.
//
// Ports
//   clk           fast system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   slow_in       divided clock, asynchronous to clk
//   rise_tick     1-cycle pulse per accepted rising edge of slow_in
//   fall_tick     1-cycle pulse per accepted falling edge of slow_in
//   scaler_out    recovered scaler value, changes only on entry to lock
//   scaler_valid  high while locked
//   timeout       1-cycle pulse when the counter saturates without an edge
//
// Build option
//   CLOCK_PERIOD_METER_GLITCH_FILTER_EN : adds a persistence filter after the
//   synchronizer so single-cycle pulses are rejected (one extra cycle of edge
//   latency, minimum measurable interval becomes 2).
module clock_period_meter #(
  parameter int SCALER_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  slow_in,
  output logic                  rise_tick,
  output logic                  fall_tick,
  output logic [SCALER_WIDTH:0] scaler_out,
  output logic                  scaler_valid,
  output logic                  timeout
);

  localparam int            CW      = SCALER_WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic          lvl;
  logic          edge_det;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last_n;

`ifdef CLOCK_PERIOD_METER_GLITCH_FILTER_EN
  logic f;

  // f only follows s2 when s1 already agrees, i.e. the new level has been
  // present on two consecutive samples; a lone 1-cycle pulse never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      f  <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_in;
      s2 <= s1;
      if (s1 == s2) f <= s2;
      s3 <= f;
    end
  end

  assign lvl = f;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl = s2;
`endif

  // s3 is the previously accepted level; any difference is an edge.
  assign edge_det = lvl ^ s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_n       <= '0;
      scaler_out   <= '0;
      scaler_valid <= 1'b0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      rise_tick <= edge_det & lvl;
      fall_tick <= edge_det & ~lvl;
      timeout   <= 1'b0;
      if (edge_det) begin
        // cnt holds the distance to the previous edge; restart at 1 so the
        // next edge N cycles later sees exactly N.
        cnt <= CNT_ONE;
        case (state)
          IDLE: state <= MEASURE;
          MEASURE: begin
            last_n <= cnt;
            if (cnt == last_n) begin
              state        <= LOCKED;
              scaler_out   <= cnt - CNT_ONE;
              scaler_valid <= 1'b1;
            end
          end
          LOCKED: begin
            last_n <= cnt;
            if (cnt != last_n) begin
              state        <= MEASURE;
              scaler_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
        // Fire only on the step into saturation, so a long stall pulses once.
        // An edge in this same cycle takes the other branch and wins.
        if (cnt == CNT_PRE) begin
          timeout      <= 1'b1;
          state        <= IDLE;
          scaler_valid <= 1'b0;
          last_n       <= '0;
        end
      end
    end
  end

endmodule
